// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sa_state_t;

  localparam int unsigned SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between the serial adder and its requester.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             Co;

  // Requester side: issues operands, observes the result.
  modport master (
    output START, A, B,
    input  BUSY, DONE, S, Co
  );

  // Adder side.
  modport slave (
    input  START, A, B,
    output BUSY, DONE, S, Co
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .A  (A),
    .B  (B),
    .S  (s0),
    .Co (c0)
  );

  half_adder u_ha1 (
    .A  (s0),
    .B  (Ci),
    .S  (S),
    .Co (c1)
  );

  // At most one of the two half-adder carries can be set.
  always_comb begin
    Co = c0 | c1;
  end

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic A,
  input  logic B,
  output logic S,
  output logic Co
);

  // Sum is the XOR, carry the AND of the two inputs.
  always_comb begin
    S  = A ^ B;
    Co = A & B;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full adder and a carry flop, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
    $error("serial_adder: WIDTH out of range");
  end

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic fa_s, fa_co;

  full_adder u_fa (
    .A  (a_sr_q[0]),
    .B  (b_sr_q[0]),
    .Ci (carry_q),
    .S  (fa_s),
    .Co (fa_co)
  );

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      co_q     <= co_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    co_d     = co_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          a_sr_d   = bus.A;
          b_sr_d   = bus.B;
          sum_sr_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: publish the complete sum including this edge's bit.
          s_d     = sum_sr_d;
          co_d    = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers only.
  always_comb begin
    bus.BUSY = (state_q != IDLE);
    bus.DONE = (state_q == DONE);
    bus.S    = s_q;
    bus.Co   = co_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with a transaction-level reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Standalone full adder for the exhaustive truth-table check.
  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  full_adder u_fa (
    .A  (fa_a),
    .B  (fa_b),
    .Ci (fa_ci),
    .S  (fa_s),
    .Co (fa_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles left in the current add (0 = idle), the pending
  // arithmetic result and the currently visible S/Co.
  int          m_rem  = 0;
  logic [W:0]  m_pend = '0;
  logic [W-1:0] m_s   = '0;
  logic        m_co   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then compare every output shortly after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rem = 0;
      m_s   = '0;
      m_co  = 1'b0;
    end else if (m_rem == 0) begin
      if (bus.START) begin
        m_pend = {1'b0, bus.A} + {1'b0, bus.B};
        m_rem  = W + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_s  = m_pend[W-1:0];
        m_co = m_pend[W];
      end
    end
    #1;
    check("busy", 32'(bus.BUSY), 32'(m_rem > 0));
    check("done", 32'(bus.DONE), 32'(m_rem == 1));
    check("sum",  32'(bus.S),    32'(m_s));
    check("cout", 32'(bus.Co),   32'(m_co));
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.START = 1'b0;
    repeat (W + 2) tick();
  endtask

  int done_seen;

  initial begin
    rst       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;

    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Basic adds including carry-out and wrap cases
    run_add(8'h00, 8'h00);
    run_add(8'hFF, 8'h01);
    run_add(8'hA5, 8'h5A);
    run_add(8'hFF, 8'hFF);

    // Operands changing after capture must not disturb the add
    bus.START = 1'b1;
    bus.A     = 8'h12;
    bus.B     = 8'h34;
    tick();
    bus.START = 1'b0;
    bus.A     = 8'hFF;
    bus.B     = 8'hFF;
    repeat (W + 6) tick();
    check("hold_sum", 32'(bus.S), 32'h46);

    // START while shifting is ignored
    bus.START = 1'b1;
    bus.A     = 8'h0F;
    bus.B     = 8'h01;
    tick();
    bus.START = 1'b0;
    repeat (2) tick();
    bus.START = 1'b1;
    bus.A     = 8'h80;
    bus.B     = 8'h80;
    tick();
    bus.START = 1'b0;
    done_seen = 0;
    repeat (W + 4) begin
      tick();
      if (bus.DONE) done_seen++;
    end
    check("ignored_start_sum", 32'(bus.S), 32'h10);
    check("single_done", 32'(done_seen), 32'd1);

    // Reset in the middle of an add
    bus.START = 1'b1;
    bus.A     = 8'h77;
    bus.B     = 8'h11;
    tick();
    bus.START = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_seen = 0;
    repeat (W + 2) begin
      tick();
      if (bus.DONE) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_add(8'h10, 8'h20);

    // START held high: one add every W+2 cycles
    bus.START = 1'b1;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    done_seen = 0;
    repeat (3 * (W + 2)) begin
      tick();
      if (bus.DONE) done_seen++;
    end
    bus.START = 1'b0;
    repeat (W + 2) tick();
    check("b2b_done_count", 32'(done_seen), 32'd3);

    // Randomized traffic with occasional resets and operand churn
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      bus.START = ($urandom_range(0, 3) == 0);
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      tick();
    end
    rst       = 1'b0;
    bus.START = 1'b0;
    repeat (W + 2) tick();

    // Exhaustive full adder truth table
    for (int v = 0; v < 8; v++) begin
      fa_a  = v[0];
      fa_b  = v[1];
      fa_ci = v[2];
      #1;
      check("fa_sum",  32'(fa_s),  32'((v[0] + v[1] + v[2]) % 2));
      check("fa_cout", 32'(fa_co), 32'((v[0] + v[1] + v[2]) / 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: latches two operands on START and adds them LSB-first, one bit per clock, through a single full adder and a carry flip-flop.
- Presents the registered N-bit sum and carry-out with a one-cycle DONE pulse.
- Sits downstream of the half-adder stage: consumes HA pairs, packaged as a full_adder, and is the first sequential arithmetic block in the lab datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- START  in  1  start request; sampled only in IDLE
- A  in  WIDTH  operand A; captured on accepted START
- B  in  WIDTH  operand B; captured on accepted START
- BUSY  out  1  high while in SHIFT or DONE
- DONE  out  1  one-cycle pulse; S/Co valid
- S  out  WIDTH  registered sum
- Co  out  1  registered carry-out

Behaviour:
- One clock (CLK); reset synchronous, active-high (RST), sampled on CLK rising edge; RST overrides all other inputs.
- Reset values:
  - state=IDLE, BUSY=0, DONE=0, S=0, Co=0.
  - Internal operand shift registers, sum shift register, carry flop and bit counter all 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - START=1 at edge k: load A and B into internal shift regs, clear carry and counter, go SHIFT.
  - START=0: stay.
  - S/Co hold their last result.
- SHIFT, one bit per edge:
  - full_adder(a_sr[0], b_sr[0], carry) produces sum bit and carry-out.
  - Sum bit shifts into sum_sr MSB; sum_sr shifts right.
  - a_sr and b_sr shift right, zero-fill.
  - carry <= cout; counter increments.
  - On the edge where counter==WIDTH-1: load S with the final sum_sr value (including this edge's bit), load Co with this edge's cout, go DONE.
  - SHIFT therefore occupies edges k+1..k+WIDTH.
- DONE:
  - DONE=1 and BUSY=1 during the cycle after edge k+WIDTH.
  - Next edge unconditionally returns to IDLE; DONE falls.
- Latency: START sampled at edge k gives S/Co/DONE valid after edge k+WIDTH. Throughput is one add per WIDTH+2 cycles.
- Handshake and input rules:
  - START is ignored in SHIFT and DONE; no queuing.
  - START held high in IDLE starts a new add each time IDLE is re-entered.
  - A/B changing after capture has no effect on the in-flight add.
- Arithmetic:
  - Unsigned; S = (A+B) mod 2^WIDTH; Co = bit WIDTH of A+B.
  - Counter width $clog2(WIDTH); no wrap past WIDTH-1.
- RST mid-operation: abort the add, all outputs return to reset values at that edge, IDLE next cycle; no partial S visible.
- S and Co change only on the SHIFT→DONE edge or on reset; they are never driven from the shift registers combinationally.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
  - localparam SA_MAX_WIDTH = 32.
- Sub-module full_adder (ports A, B, Ci, S, Co):
  - Purely combinational, built from two HA instances plus an OR of their carries.
  - Instantiated once in serial_adder.

Test Plan (WIDTH=8, edge k = START sample):
1. RST high 2 cycles, then low → S=0x00, Co=0, BUSY=0, DONE=0; START=1 with A=0x00, B=0x00 → after edge k+8: S=0x00, Co=0, DONE=1 for exactly one cycle, BUSY=1 across edges k+1..k+9.
2. A=0xFF, B=0x01 → S=0x00, Co=1 at DONE; A=0xA5, B=0x5A → S=0xFF, Co=0; A=0xFF, B=0xFF → S=0xFE, Co=1.
3. Capture isolation: START with A=0x12, B=0x34, then set A=0xFF, B=0xFF on the next cycle → S=0x46, Co=0; S holds 0x46 in IDLE until the next START.
4. Ignored START: START with A=0x0F, B=0x01; pulse START at edge k+3 with A=0x80, B=0x80 → result S=0x10, Co=0; no second DONE without a new IDLE START.
5. Mid-operation reset: START with A=0x77, B=0x11; RST at edge k+4 → S=0x00, Co=0, BUSY=0, DONE=0 at that edge, no DONE pulse; then START A=0x10, B=0x20 → S=0x30, Co=0 after 8 shift edges.
6. Back-to-back: START held high with A=0x01, B=0x01 → DONE pulses every 10 cycles, S=0x02 each time; full_adder exhaustive check over all 8 input combinations in a separate unit bench.
